// File: rtl/uart_cmd_parser.sv
// rtl/uart_cmd_parser.sv - assembles 6-byte UART command frames into register requests
// Frame: sync, cmd, addr, data-hi, data-lo, XOR checksum of cmd..data-lo.
module uart_cmd_parser #(
  parameter logic [7:0] SYNC_BYTE      = 8'hAA,
  parameter logic [7:0] CMD_WR         = 8'h57,
  parameter logic [7:0] CMD_RD         = 8'h52,
  parameter int         TIMEOUT_CYCLES = 50000,
  parameter int         TO_W           = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  byte_in,
  input  logic        byte_rdy,
  output logic        reg_wr_en,
  output logic        reg_rd_en,
  output logic [7:0]  reg_addr,
  output logic [15:0] reg_wdata,
  output logic        frame_err,
  output logic [1:0]  err_code,
  output logic        busy
);

  typedef enum logic [2:0] {IDLE, CMD, ADDR, DHI, DLO, CHK} state_t;

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  state_t          state, state_n;
  logic [TO_W-1:0] cnt, cnt_n;
  logic [7:0]      xor_r, xor_n;
  logic            is_wr, is_wr_n;
  logic [7:0]      addr_buf, addr_buf_n;
  logic [7:0]      dhi_buf, dhi_buf_n;
  logic [7:0]      dlo_buf, dlo_buf_n;
  logic            wr_n, rd_n, err_n;
  logic [1:0]      code_n;
  logic [7:0]      reg_addr_n;
  logic [15:0]     reg_wdata_n;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      xor_r     <= '0;
      is_wr     <= 1'b0;
      addr_buf  <= '0;
      dhi_buf   <= '0;
      dlo_buf   <= '0;
      reg_wr_en <= 1'b0;
      reg_rd_en <= 1'b0;
      frame_err <= 1'b0;
      err_code  <= '0;
      reg_addr  <= '0;
      reg_wdata <= '0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      xor_r     <= xor_n;
      is_wr     <= is_wr_n;
      addr_buf  <= addr_buf_n;
      dhi_buf   <= dhi_buf_n;
      dlo_buf   <= dlo_buf_n;
      reg_wr_en <= wr_n;
      reg_rd_en <= rd_n;
      frame_err <= err_n;
      err_code  <= code_n;
      reg_addr  <= reg_addr_n;
      reg_wdata <= reg_wdata_n;
    end
  end

  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    xor_n       = xor_r;
    is_wr_n     = is_wr;
    addr_buf_n  = addr_buf;
    dhi_buf_n   = dhi_buf;
    dlo_buf_n   = dlo_buf;
    wr_n        = 1'b0;
    rd_n        = 1'b0;
    err_n       = 1'b0;
    code_n      = err_code;
    reg_addr_n  = reg_addr;
    reg_wdata_n = reg_wdata;

    if (state != IDLE)
      cnt_n = cnt + 1'b1;

    // An arriving byte always beats a simultaneous timeout.
    if (byte_rdy) begin
      cnt_n = '0;
      case (state)
        IDLE: if (byte_in == SYNC_BYTE) state_n = CMD;
        CMD: begin
          if (byte_in == CMD_WR || byte_in == CMD_RD) begin
            is_wr_n = (byte_in == CMD_WR);
            xor_n   = byte_in;
            state_n = ADDR;
          end else begin
            err_n   = 1'b1;
            code_n  = 2'd1;
            state_n = IDLE;
          end
        end
        ADDR: begin
          addr_buf_n = byte_in;
          xor_n      = xor_r ^ byte_in;
          state_n    = DHI;
        end
        DHI: begin
          dhi_buf_n = byte_in;
          xor_n     = xor_r ^ byte_in;
          state_n   = DLO;
        end
        DLO: begin
          dlo_buf_n = byte_in;
          xor_n     = xor_r ^ byte_in;
          state_n   = CHK;
        end
        CHK: begin
          if (byte_in == xor_r) begin
            reg_addr_n = addr_buf;
            if (is_wr) begin
              reg_wdata_n = {dhi_buf, dlo_buf};
              wr_n        = 1'b1;
            end else begin
              rd_n = 1'b1;
            end
          end else begin
            err_n  = 1'b1;
            code_n = 2'd2;
          end
          state_n = IDLE;
        end
        default: state_n = IDLE;
      endcase
    end else if (state != IDLE && cnt == TO_LAST) begin
      err_n   = 1'b1;
      code_n  = 2'd3;
      cnt_n   = '0;
      state_n = IDLE;
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_uart_cmd_parser.sv
// tb/tb_uart_cmd_parser.sv - directed self-checking bench for uart_cmd_parser
module tb_uart_cmd_parser;

  localparam int TO = 20;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  byte_in = '0;
  logic        byte_rdy = 1'b0;
  logic        reg_wr_en, reg_rd_en, frame_err, busy;
  logic [7:0]  reg_addr;
  logic [15:0] reg_wdata;
  logic [1:0]  err_code;

  int n_cmp = 0;
  int n_bad = 0;

  uart_cmd_parser #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .byte_in(byte_in), .byte_rdy(byte_rdy),
    .reg_wr_en(reg_wr_en), .reg_rd_en(reg_rd_en), .reg_addr(reg_addr),
    .reg_wdata(reg_wdata), .frame_err(frame_err), .err_code(err_code), .busy(busy)
  );

  always #5 clk = ~clk;

  // Byte is presented across one posedge; task returns on the following negedge.
  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    byte_in  = b;
    byte_rdy = 1'b1;
    @(negedge clk);
    byte_rdy = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] b0, b1, b2, b3, b4, b5);
    send_byte(b0); send_byte(b1); send_byte(b2);
    send_byte(b3); send_byte(b4); send_byte(b5);
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({reg_wr_en, reg_rd_en, frame_err, busy, err_code, reg_addr, reg_wdata} !== 30'd0) begin
      n_bad++;
      $display("FAIL reset_outputs got wr=%b rd=%b err=%b busy=%b code=%0d addr=%h wdata=%h want all 0",
               reg_wr_en, reg_rd_en, frame_err, busy, err_code, reg_addr, reg_wdata);
    end
    rst = 1'b0;
  endtask

  task automatic test_write;
    send_frame(8'hAA, 8'h57, 8'h10, 8'h12, 8'h34, 8'h61);
    n_cmp++;
    if ({reg_wr_en, reg_rd_en, frame_err, reg_addr, reg_wdata} !== {3'b100, 8'h10, 16'h1234}) begin
      n_bad++;
      $display("FAIL write_strobe got wr=%b rd=%b err=%b addr=%h wdata=%h want 1 0 0 10 1234",
               reg_wr_en, reg_rd_en, frame_err, reg_addr, reg_wdata);
    end
    @(negedge clk);
    n_cmp++;
    if ({reg_wr_en, busy} !== 2'b00) begin
      n_bad++;
      $display("FAIL write_one_cycle got wr=%b busy=%b want 0 0", reg_wr_en, busy);
    end
  endtask

  task automatic test_read;
    send_frame(8'hAA, 8'h52, 8'h05, 8'h00, 8'h00, 8'h57);
    n_cmp++;
    if ({reg_wr_en, reg_rd_en, frame_err, reg_addr, reg_wdata} !== {3'b010, 8'h05, 16'h1234}) begin
      n_bad++;
      $display("FAIL read_strobe got wr=%b rd=%b err=%b addr=%h wdata=%h want 0 1 0 05 1234",
               reg_wr_en, reg_rd_en, frame_err, reg_addr, reg_wdata);
    end
    @(negedge clk);
    n_cmp++;
    if (reg_rd_en !== 1'b0) begin
      n_bad++;
      $display("FAIL read_one_cycle got rd=%b want 0", reg_rd_en);
    end
  endtask

  task automatic test_bad_checksum;
    send_frame(8'hAA, 8'h57, 8'h10, 8'h12, 8'h34, 8'h60);
    n_cmp++;
    if ({reg_wr_en, reg_rd_en, frame_err, err_code, reg_addr, reg_wdata} !==
        {3'b001, 2'd2, 8'h05, 16'h1234}) begin
      n_bad++;
      $display("FAIL bad_checksum got wr=%b rd=%b err=%b code=%0d addr=%h wdata=%h want 0 0 1 2 05 1234",
               reg_wr_en, reg_rd_en, frame_err, err_code, reg_addr, reg_wdata);
    end
    @(negedge clk);
    n_cmp++;
    if ({frame_err, err_code} !== {1'b0, 2'd2}) begin
      n_bad++;
      $display("FAIL err_hold got err=%b code=%0d want 0 2", frame_err, err_code);
    end
    send_frame(8'hAA, 8'h57, 8'h20, 8'hAB, 8'hCD, 8'h11);
    n_cmp++;
    if ({reg_wr_en, frame_err, reg_addr, reg_wdata} !== {2'b10, 8'h20, 16'hABCD}) begin
      n_bad++;
      $display("FAIL recover_write got wr=%b err=%b addr=%h wdata=%h want 1 0 20 abcd",
               reg_wr_en, frame_err, reg_addr, reg_wdata);
    end
  endtask

  task automatic test_bad_cmd;
    send_byte(8'h00);
    send_byte(8'hFF);
    n_cmp++;
    if ({busy, frame_err} !== 2'b00) begin
      n_bad++;
      $display("FAIL idle_ignore got busy=%b err=%b want 0 0", busy, frame_err);
    end
    send_byte(8'hAA);
    n_cmp++;
    if (busy !== 1'b1) begin
      n_bad++;
      $display("FAIL busy_after_sync got %b want 1", busy);
    end
    send_byte(8'h41);
    n_cmp++;
    if ({frame_err, err_code, busy} !== {1'b1, 2'd1, 1'b0}) begin
      n_bad++;
      $display("FAIL bad_cmd got err=%b code=%0d busy=%b want 1 1 0", frame_err, err_code, busy);
    end
    // A second sync in CMD is a bad command, not a resync.
    send_byte(8'hAA);
    send_byte(8'hAA);
    n_cmp++;
    if ({frame_err, err_code, busy} !== {1'b1, 2'd1, 1'b0}) begin
      n_bad++;
      $display("FAIL sync_in_cmd got err=%b code=%0d busy=%b want 1 1 0", frame_err, err_code, busy);
    end
  endtask

  task automatic test_timeout;
    send_byte(8'hAA);
    send_byte(8'h57);
    repeat (TO - 1) @(negedge clk);
    n_cmp++;
    if ({frame_err, busy} !== 2'b01) begin
      n_bad++;
      $display("FAIL timeout_early got err=%b busy=%b want 0 1", frame_err, busy);
    end
    @(negedge clk);
    n_cmp++;
    if ({frame_err, err_code, busy} !== {1'b1, 2'd3, 1'b0}) begin
      n_bad++;
      $display("FAIL timeout got err=%b code=%0d busy=%b want 1 3 0", frame_err, err_code, busy);
    end
  endtask

  task automatic test_timeout_race;
    send_byte(8'hAA);
    send_byte(8'h57);
    repeat (TO - 2) @(negedge clk);
    send_byte(8'h10);
    n_cmp++;
    if ({frame_err, busy} !== 2'b01) begin
      n_bad++;
      $display("FAIL byte_on_expiry got err=%b busy=%b want 0 1", frame_err, busy);
    end
    send_byte(8'h12);
    send_byte(8'h34);
    send_byte(8'h61);
    n_cmp++;
    if ({reg_wr_en, frame_err, reg_addr, reg_wdata} !== {2'b10, 8'h10, 16'h1234}) begin
      n_bad++;
      $display("FAIL race_write got wr=%b err=%b addr=%h wdata=%h want 1 0 10 1234",
               reg_wr_en, frame_err, reg_addr, reg_wdata);
    end
  endtask

  task automatic test_reset_mid_frame;
    send_byte(8'hAA);
    send_byte(8'h57);
    send_byte(8'h10);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({reg_wr_en, reg_rd_en, frame_err, busy, err_code, reg_addr, reg_wdata} !== 30'd0) begin
      n_bad++;
      $display("FAIL reset_mid_frame got wr=%b rd=%b err=%b busy=%b code=%0d addr=%h wdata=%h want all 0",
               reg_wr_en, reg_rd_en, frame_err, busy, err_code, reg_addr, reg_wdata);
    end
    rst = 1'b0;
    send_frame(8'hAA, 8'h57, 8'h33, 8'h55, 8'h66, 8'h57 ^ 8'h33 ^ 8'h55 ^ 8'h66);
    n_cmp++;
    if ({reg_wr_en, frame_err, reg_addr, reg_wdata} !== {2'b10, 8'h33, 16'h5566}) begin
      n_bad++;
      $display("FAIL post_reset_write got wr=%b err=%b addr=%h wdata=%h want 1 0 33 5566",
               reg_wr_en, frame_err, reg_addr, reg_wdata);
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_bad_checksum();
    test_bad_cmd();
    test_timeout();
    test_timeout_race();
    test_reset_mid_frame();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
